// File: rtl/datapath_seq_pkg.sv
// datapath_seq_pkg: shared types for the sequenced datapath.
//   cmd_kind_t : command kinds (MOVI/MOVR/ALU/CMP/LDM/LDPC, 6/7 reserved)
//   aluop_t    : ALU operations
//   shift_t    : one-bit B-operand shifts
//   state_t    : micro-sequencer states (S_RDAB used only with dual read ports)
//   ctrl_t     : control fields latched at command accept
//   ST_*       : bit positions inside status = {V,N,Z}
package datapath_seq_pkg;

    typedef enum logic [2:0] {
        K_MOVI = 3'd0, K_MOVR = 3'd1, K_ALU  = 3'd2, K_CMP  = 3'd3,
        K_LDM  = 3'd4, K_LDPC = 3'd5, K_RSV6 = 3'd6, K_RSV7 = 3'd7
    } cmd_kind_t;

    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_AND, OP_MVN} aluop_t;

    typedef enum logic [1:0] {SH_NONE, SH_LSL1, SH_LSR1, SH_ASR1} shift_t;

    typedef enum logic [2:0] {S_IDLE, S_RDA, S_RDB, S_RDAB, S_EXEC, S_WB} state_t;

    typedef struct packed {
        cmd_kind_t kind;
        aluop_t    aluop;
        shift_t    shift;
        logic      bsel;
    } ctrl_t;

    localparam int ST_Z = 0;
    localparam int ST_N = 1;
    localparam int ST_V = 2;

endpackage

// File: rtl/dp_regfile.sv
// dp_regfile: NREG x DW register file, one write port, NRP read ports
// (1 or 2) and a debug read port. All reads are combinational.
//   clk, reset_n   : clock, async active-low reset (clears every entry)
//   we/waddr/wdata : write port, takes effect at the rising edge
//   raddr/rdata    : NRP packed read ports
//   dbg_raddr/dbg_rdata : debug read port
module dp_regfile #(
    parameter int DW   = 16,
    parameter int NREG = 8,
    parameter int NRP  = 1,
    parameter int RW   = $clog2(NREG)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     we,
    input  logic [RW-1:0]            waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [NRP-1:0][RW-1:0]   raddr,
    output logic [NRP-1:0][DW-1:0]   rdata,
    input  logic [RW-1:0]            dbg_raddr,
    output logic [DW-1:0]            dbg_rdata
);

    logic [NREG-1:0][DW-1:0] mem;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  mem <= '0;
        else if (we)   mem[waddr] <= wdata;
    end

    for (genvar p = 0; p < NRP; p++) begin : g_rd
        assign rdata[p] = mem[raddr[p]];
    end

    assign dbg_rdata = mem[dbg_raddr];

endmodule

// File: rtl/datapath_seq.sv
// datapath_seq: register file + A/B/C registers + shifter + ALU + status,
// driven by an internal micro-sequencer. One accepted command runs a whole
// instruction (read, execute, writeback).
//   clk, reset_n        : clock, async active-low reset (aborts any command)
//   cmd_valid/cmd_ready : command handshake, ready only in IDLE
//   cmd_kind/aluop/shift/rd/rn/rm/bsel, sximm8, sximm5 : latched at accept
//   mdata, PC           : sampled during the WB cycle
//   datapath_out        : C register
//   status              : {V,N,Z}, updated in EXEC of ALU/CMP only
//   done                : one-cycle pulse in the final cycle of a command
//   dbg_rnum/dbg_rdata  : combinational debug read of the register file
// Build option: DATAPATH_SEQ_DUALREAD_EN gives the register file two read
// ports and merges RDA/RDB into RDAB (ALU 3 cycles, CMP 2 cycles).
module datapath_seq
    import datapath_seq_pkg::*;
#(
    parameter int DW   = 16,
    parameter int NREG = 8,
    parameter int PCW  = 8,
    parameter int RW   = $clog2(NREG)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [2:0]     cmd_kind,
    input  logic [1:0]     cmd_aluop,
    input  logic [1:0]     cmd_shift,
    input  logic [RW-1:0]  cmd_rd,
    input  logic [RW-1:0]  cmd_rn,
    input  logic [RW-1:0]  cmd_rm,
    input  logic           cmd_bsel,
    input  logic [DW-1:0]  sximm8,
    input  logic [DW-1:0]  sximm5,
    input  logic [DW-1:0]  mdata,
    input  logic [PCW-1:0] PC,
    output logic [DW-1:0]  datapath_out,
    output logic [2:0]     status,
    output logic           done,
    input  logic [RW-1:0]  dbg_rnum,
    output logic [DW-1:0]  dbg_rdata
);

`ifdef DATAPATH_SEQ_DUALREAD_EN
    localparam int NRP = 2;
`else
    localparam int NRP = 1;
`endif

    state_t                  state;
    ctrl_t                   ctl;
    logic [RW-1:0]           rd, rn, rm;
    logic [DW-1:0]           imm8, imm5, a_q, b_q, c_q;
    logic [2:0]              st_q;
    logic                    done_q;

    logic [NRP-1:0][RW-1:0]  raddr;
    logic [NRP-1:0][DW-1:0]  rdata;
    logic [DW-1:0]           rd_a, rd_b, wdata;
    logic [DW-1:0]           b_sh, ain, bin, res;
    aluop_t                  op;
    logic                    vflag;

`ifdef DATAPATH_SEQ_DUALREAD_EN
    assign raddr[0] = rn;
    assign raddr[1] = rm;
    assign rd_a     = rdata[0];
    assign rd_b     = rdata[1];
`else
    // Single port is time-shared: Rn during RDA, Rm otherwise.
    assign raddr[0] = (state == S_RDA) ? rn : rm;
    assign rd_a     = rdata[0];
    assign rd_b     = rdata[0];
`endif

    dp_regfile #(.DW(DW), .NREG(NREG), .NRP(NRP), .RW(RW)) u_rf (
        .clk       (clk),
        .reset_n   (reset_n),
        .we        (state == S_WB),
        .waddr     (rd),
        .wdata     (wdata),
        .raddr     (raddr),
        .rdata     (rdata),
        .dbg_raddr (dbg_rnum),
        .dbg_rdata (dbg_rdata)
    );

    // Shifter + ALU. MOVR reuses the adder as 0 + Bin.
    always_comb begin
        b_sh = b_q;
        case (ctl.shift)
            SH_LSL1: b_sh = {b_q[DW-2:0], 1'b0};
            SH_LSR1: b_sh = {1'b0, b_q[DW-1:1]};
            SH_ASR1: b_sh = {b_q[DW-1], b_q[DW-1:1]};
            default: b_sh = b_q;
        endcase
        bin   = ctl.bsel ? imm5 : b_sh;
        ain   = (ctl.kind == K_MOVR) ? '0 : a_q;
        op    = (ctl.kind == K_MOVR) ? OP_ADD : ctl.aluop;
        res   = '0;
        vflag = 1'b0;
        case (op)
            OP_ADD: begin
                res   = ain + bin;
                vflag = (ain[DW-1] == bin[DW-1]) && (res[DW-1] != ain[DW-1]);
            end
            OP_SUB: begin
                res   = ain + ~bin + {{(DW-1){1'b0}}, 1'b1};
                vflag = (ain[DW-1] != bin[DW-1]) && (res[DW-1] != ain[DW-1]);
            end
            OP_AND:  res = ain & bin;
            default: res = ~bin;
        endcase
    end

    always_comb begin
        case (ctl.kind)
            K_MOVI:  wdata = imm8;
            K_LDM:   wdata = mdata;
            K_LDPC:  wdata = DW'(PC);
            default: wdata = c_q;
        endcase
    end

    // done is registered: it is set on the edge entering the final cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            ctl    <= '0;
            rd     <= '0;
            rn     <= '0;
            rm     <= '0;
            imm8   <= '0;
            imm5   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            st_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: if (cmd_valid) begin
                    ctl  <= '{kind:  cmd_kind_t'(cmd_kind), aluop: aluop_t'(cmd_aluop),
                              shift: shift_t'(cmd_shift),   bsel:  cmd_bsel};
                    rd   <= cmd_rd;
                    rn   <= cmd_rn;
                    rm   <= cmd_rm;
                    imm8 <= sximm8;
                    imm5 <= sximm5;
                    case (cmd_kind_t'(cmd_kind))
                        K_MOVI, K_LDM, K_LDPC: begin
                            state  <= S_WB;
                            done_q <= 1'b1;
                        end
                        K_MOVR: state <= S_RDB;
`ifdef DATAPATH_SEQ_DUALREAD_EN
                        K_ALU, K_CMP: state <= S_RDAB;
`else
                        K_ALU, K_CMP: state <= S_RDA;
`endif
                        default: done_q <= 1'b1;   // reserved: acknowledge only
                    endcase
                end
                S_RDA: begin
                    a_q   <= rd_a;
                    state <= S_RDB;
                end
                S_RDB: begin
                    b_q    <= rd_b;
                    state  <= S_EXEC;
                    done_q <= (ctl.kind == K_CMP);
                end
                S_RDAB: begin
                    a_q    <= rd_a;
                    b_q    <= rd_b;
                    state  <= S_EXEC;
                    done_q <= (ctl.kind == K_CMP);
                end
                S_EXEC: begin
                    c_q <= res;
                    if (ctl.kind == K_ALU || ctl.kind == K_CMP)
                        st_q <= {vflag, res[DW-1], res == '0};
                    if (ctl.kind == K_CMP) begin
                        state <= S_IDLE;
                    end else begin
                        state  <= S_WB;
                        done_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;   // S_WB: write happens on this edge
            endcase
        end
    end

    assign cmd_ready    = (state == S_IDLE);
    assign datapath_out = c_q;
    assign status       = st_q;
    assign done         = done_q;

endmodule

// File: tb/tb_datapath_seq.sv
module tb_datapath_seq;
    import datapath_seq_pkg::*;

`ifdef DATAPATH_SEQ_DUALREAD_EN
    localparam int LAT_ALU = 3;
    localparam int LAT_CMP = 2;
`else
    localparam int LAT_ALU = 4;
    localparam int LAT_CMP = 3;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  cmd_kind;
    logic [1:0]  cmd_aluop, cmd_shift;
    logic [3:0]  cmd_rd, cmd_rn, cmd_rm, dbg_rnum;
    logic        cmd_bsel;
    logic [31:0] sximm8, sximm5, mdata;
    logic [7:0]  pc;
    logic        vld_s, vld_b;

    logic        rdy_s, done_s, rdy_b, done_b;
    logic [15:0] out_s, dbg_s;
    logic [31:0] out_b, dbg_b;
    logic [2:0]  st_s, st_b;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    datapath_seq u_dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(vld_s), .cmd_ready(rdy_s),
        .cmd_kind(cmd_kind), .cmd_aluop(cmd_aluop), .cmd_shift(cmd_shift),
        .cmd_rd(cmd_rd[2:0]), .cmd_rn(cmd_rn[2:0]), .cmd_rm(cmd_rm[2:0]),
        .cmd_bsel(cmd_bsel), .sximm8(sximm8[15:0]), .sximm5(sximm5[15:0]),
        .mdata(mdata[15:0]), .PC(pc),
        .datapath_out(out_s), .status(st_s), .done(done_s),
        .dbg_rnum(dbg_rnum[2:0]), .dbg_rdata(dbg_s)
    );

    datapath_seq #(.DW(32), .NREG(16)) u_big (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(vld_b), .cmd_ready(rdy_b),
        .cmd_kind(cmd_kind), .cmd_aluop(cmd_aluop), .cmd_shift(cmd_shift),
        .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
        .cmd_bsel(cmd_bsel), .sximm8(sximm8), .sximm5(sximm5),
        .mdata(mdata), .PC(pc),
        .datapath_out(out_b), .status(st_b), .done(done_b),
        .dbg_rnum(dbg_rnum), .dbg_rdata(dbg_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic set_cmd(input logic [2:0] k, input logic [1:0] op, input logic [1:0] sh,
                           input logic [3:0] d, input logic [3:0] n, input logic [3:0] m,
                           input logic bs, input logic [31:0] i8, input logic [31:0] i5);
        cmd_kind = k;  cmd_aluop = op; cmd_shift = sh;
        cmd_rd = d;    cmd_rn = n;     cmd_rm = m;
        cmd_bsel = bs; sximm8 = i8;    sximm5 = i5;
    endtask

    // Issue one command, measure accept-edge to done-cycle-edge latency,
    // return just after the final edge (block back in IDLE).
    task automatic issue(input bit big, input logic [2:0] k, input logic [1:0] op,
                         input logic [1:0] sh, input logic [3:0] d, input logic [3:0] n,
                         input logic [3:0] m, input logic bs, input logic [31:0] i8,
                         input logic [31:0] i5, input int exp_lat, input string tag);
        int lat;
        @(negedge clk);
        chk({tag, " ready"}, 32'(big ? rdy_b : rdy_s), 32'd1);
        set_cmd(k, op, sh, d, n, m, bs, i8, i5);
        if (big) vld_b = 1'b1; else vld_s = 1'b1;
        @(posedge clk); #1;
        vld_s = 1'b0; vld_b = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (big ? done_b : done_s) break;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        @(posedge clk); #1;
    endtask

    task automatic reg_chk(input bit big, input logic [3:0] r, input logic [31:0] exp,
                           input string tag);
        dbg_rnum = r;
        #1;
        chk(tag, big ? dbg_b : 32'(dbg_s), exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vld_s = 1'b0; vld_b = 1'b0; dbg_rnum = '0; mdata = '0; pc = '0;
        set_cmd(3'd0, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        #1;
        chk("rst ready", 32'(rdy_s), 32'd1);
        chk("rst out", 32'(out_s), 32'd0);
        chk("rst status", 32'(st_s), 32'd0);
        chk("rst done", 32'(done_s), 32'd0);
        reg_chk(0, 4'd5, 32'd0, "rst R5");

        // ADD R5,R3,R2 = 42+13
        issue(0, K_MOVI, 0, 0, 4'd2, 0, 0, 0, 32'd13, 0, 1, "movi r2");
        issue(0, K_MOVI, 0, 0, 4'd3, 0, 0, 0, 32'd42, 0, 1, "movi r3");
        issue(0, K_ALU, OP_ADD, SH_NONE, 4'd5, 4'd3, 4'd2, 0, 0, 0, LAT_ALU, "add");
        chk("add out", 32'(out_s), 32'd55);
        chk("add status", 32'(st_s), 32'd0);
        reg_chk(0, 4'd5, 32'd55, "add R5");

        // ADD R2,R1,R0 LSL1 = 2 + 14
        issue(0, K_MOVI, 0, 0, 4'd0, 0, 0, 0, 32'd7, 0, 1, "movi r0");
        issue(0, K_MOVI, 0, 0, 4'd1, 0, 0, 0, 32'd2, 0, 1, "movi r1");
        issue(0, K_ALU, OP_ADD, SH_LSL1, 4'd2, 4'd1, 4'd0, 0, 0, 0, LAT_ALU, "add lsl");
        reg_chk(0, 4'd2, 32'd16, "add lsl R2");

        // CMP R0,R0 with rd=R7 must not write R7
        issue(0, K_MOVI, 0, 0, 4'd0, 0, 0, 0, 32'd5, 0, 1, "movi r0=5");
        issue(0, K_CMP, OP_SUB, SH_NONE, 4'd7, 4'd0, 4'd0, 0, 0, 0, LAT_CMP, "cmp eq");
        chk("cmp eq status", 32'(st_s), 32'b001);
        chk("cmp eq out", 32'(out_s), 32'd0);
        reg_chk(0, 4'd7, 32'd0, "cmp eq R7");
        reg_chk(0, 4'd0, 32'd5, "cmp eq R0");

        // 0x8000 - 1 overflows
        issue(0, K_MOVI, 0, 0, 4'd1, 0, 0, 0, 32'h8000, 0, 1, "movi r1=8000");
        issue(0, K_MOVI, 0, 0, 4'd3, 0, 0, 0, 32'd1, 0, 1, "movi r3=1");
        issue(0, K_CMP, OP_SUB, SH_NONE, 4'd0, 4'd1, 4'd3, 0, 0, 0, LAT_CMP, "cmp ov");
        chk("cmp ov out", 32'(out_s), 32'h7FFF);
        chk("cmp ov status", 32'(st_s), 32'b100);

        // loads; status untouched
        mdata = 32'h0000BEEF; pc = 8'hA5;
        issue(0, K_LDM, 0, 0, 4'd6, 0, 0, 0, 0, 0, 1, "ldm");
        reg_chk(0, 4'd6, 32'hBEEF, "ldm R6");
        issue(0, K_LDPC, 0, 0, 4'd7, 0, 0, 0, 0, 0, 1, "ldpc");
        reg_chk(0, 4'd7, 32'h00A5, "ldpc R7");
        chk("load status", 32'(st_s), 32'b100);

        // MOVR R4 <- R6 LSR1
        issue(0, K_MOVR, OP_AND, SH_LSR1, 4'd4, 0, 4'd6, 0, 0, 0, 3, "movr");
        reg_chk(0, 4'd4, 32'h5F77, "movr R4");
        chk("movr status", 32'(st_s), 32'b100);

        // AND R5, R6, R6 ASR1 : BEEF & DF77
        issue(0, K_ALU, OP_AND, SH_ASR1, 4'd5, 4'd6, 4'd6, 0, 0, 0, LAT_ALU, "and asr");
        reg_chk(0, 4'd5, 32'h9E67, "and asr R5");
        chk("and asr status", 32'(st_s), 32'b010);

        // SUB R5, R3, #2 : 1 - 2
        issue(0, K_ALU, OP_SUB, SH_NONE, 4'd5, 4'd3, 4'd0, 1, 0, 32'd2, LAT_ALU, "sub imm");
        chk("sub imm out", 32'(out_s), 32'hFFFF);
        chk("sub imm status", 32'(st_s), 32'b010);

        // MVN R0, R2 : ~16
        issue(0, K_ALU, OP_MVN, SH_NONE, 4'd0, 4'd5, 4'd2, 0, 0, 0, LAT_ALU, "mvn");
        reg_chk(0, 4'd0, 32'hFFEF, "mvn R0");

        // 0x7FFF + 1 overflows positive
        issue(0, K_MOVI, 0, 0, 4'd1, 0, 0, 0, 32'h7FFF, 0, 1, "movi r1=7fff");
        issue(0, K_ALU, OP_ADD, SH_NONE, 4'd2, 4'd1, 4'd0, 1, 0, 32'd1, LAT_ALU, "add ov");
        reg_chk(0, 4'd2, 32'h8000, "add ov R2");
        chk("add ov status", 32'(st_s), 32'b110);

        // reserved kind: one-cycle acknowledge, nothing changes
        issue(0, K_RSV6, 0, 0, 4'd2, 0, 0, 0, 32'd77, 0, 1, "reserved");
        chk("reserved out", 32'(out_s), 32'h8000);
        chk("reserved status", 32'(st_s), 32'b110);
        reg_chk(0, 4'd2, 32'h8000, "reserved R2");

        // busy: second command held valid must wait for IDLE
        @(negedge clk);
        set_cmd(K_ALU, OP_ADD, SH_NONE, 4'd5, 4'd3, 4'd2, 0, 0, 0);   // 1 + 0x8000
        vld_s = 1'b1;
        @(posedge clk); #1;
        set_cmd(K_MOVI, 0, 0, 4'd6, 0, 0, 0, 32'd99, 0);
        for (int i = 0; i < LAT_ALU; i++) begin
            @(negedge clk);
            chk("busy ready", 32'(rdy_s), 32'd0);
        end
        chk("busy done", 32'(done_s), 32'd1);
        @(posedge clk); #1;
        reg_chk(0, 4'd5, 32'h8001, "busy R5");
        reg_chk(0, 4'd6, 32'hBEEF, "busy R6 not queued");
        @(negedge clk);
        chk("busy idle ready", 32'(rdy_s), 32'd1);
        @(posedge clk); #1;
        vld_s = 1'b0;
        @(negedge clk);
        chk("late movi done", 32'(done_s), 32'd1);
        @(posedge clk); #1;
        reg_chk(0, 4'd6, 32'd99, "late movi R6");

        // wide instance: MVN of all-ones
        issue(1, K_MOVI, 0, 0, 4'd15, 0, 0, 0, 32'hFFFF_FFFF, 0, 1, "big movi");
        issue(1, K_ALU, OP_MVN, SH_NONE, 4'd14, 4'd0, 4'd15, 0, 0, 0, LAT_ALU, "big mvn");
        reg_chk(1, 4'd14, 32'd0, "big mvn R14");
        chk("big mvn status", 32'(st_b), 32'b001);
        reg_chk(1, 4'd15, 32'hFFFF_FFFF, "big R15");

        // reset during EXEC of ADD R4 aborts writeback
        issue(0, K_MOVI, 0, 0, 4'd2, 0, 0, 0, 32'd3, 0, 1, "movi r2=3");
        @(negedge clk);
        set_cmd(K_ALU, OP_ADD, SH_NONE, 4'd4, 4'd3, 4'd2, 0, 0, 0);
        vld_s = 1'b1;
        @(posedge clk); #1;
        vld_s = 1'b0;
        repeat (LAT_ALU - 1) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort out", 32'(out_s), 32'd0);
        chk("abort status", 32'(st_s), 32'd0);
        chk("abort done", 32'(done_s), 32'd0);
        reg_chk(0, 4'd4, 32'd0, "abort R4");
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        chk("abort ready", 32'(rdy_s), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        reg_chk(0, 4'd4, 32'd0, "abort R4 later");
        chk("abort done later", 32'(done_s), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/datapath_seq.md
Name: datapath_seq

Overview:
- Parametrised successor to the 16-bit, 8-register datapath.
- Contents: register file, A/B/C pipeline registers, shifter, ALU, status register and writeback mux, generalised to DW data bits and NREG registers.
- Adds an internal micro-sequencer. One accepted command executes a whole instruction (read, execute, writeback) without per-cycle external control.
- Sits between the instruction decoder and memory/PC logic.

Parameters:
- DW, 16, data width (>=8).
- NREG, 8, number of general registers (power of two, >=2). RW = $clog2(NREG).
- PCW, 8, PC width (<=DW).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command
- cmd_kind  in  3  0=MOVI, 1=MOVR, 2=ALU, 3=CMP, 4=LDM, 5=LDPC, 6/7 reserved
- cmd_aluop  in  2  0=ADD, 1=SUB, 2=AND, 3=MVN
- cmd_shift  in  2  0=none, 1=LSL1, 2=LSR1 (zero-fill), 3=ASR1
- cmd_rd, cmd_rn, cmd_rm  in  RW  register indices
- cmd_bsel  in  1  1: B operand = sximm5 instead of shifted Rm
- sximm8, sximm5  in  DW  sign-extended immediates, sampled at accept
- mdata  in  DW  memory data, sampled in WB cycle
- PC  in  PCW  zero-extended to DW, sampled in WB cycle
- datapath_out  out  DW  C register
- status  out  3  {V,N,Z}
- done  out  1  one-cycle pulse in WB/final cycle
- dbg_rnum  in  RW  debug read index
- dbg_rdata  out  DW  combinational read of regfile[dbg_rnum]

Behaviour:
- Reset (async, reset_n=0):
  - all regfile entries, A, B, C = 0; status = 0; state = IDLE.
  - cmd_ready = 1 after release; done = 0.
  - A reset mid-operation aborts the command; no writeback occurs.
- Handshake:
  - Accept on a rising edge with cmd_valid && cmd_ready. The command fields and immediates are latched at that edge.
  - cmd_ready = (state==IDLE). Commands offered while busy are ignored and never queued.
- FSM states: IDLE, RDA, RDB, EXEC, WB.
- Transitions:
  - MOVI, LDM, LDPC: IDLE -> WB -> IDLE.
  - MOVR: IDLE -> RDB -> EXEC -> WB.
  - ALU: IDLE -> RDA -> RDB -> EXEC -> WB.
  - CMP: IDLE -> RDA -> RDB -> EXEC (done here, no WB) -> IDLE.
- Per-state actions:
  - RDA: A <= R[rn].
  - RDB: B <= R[rm].
  - EXEC: C <= ALU(Ain, Bin).
    - Ain = A; MOVR forces Ain = 0 with op ADD.
    - Bin = cmd_bsel ? sximm5 : shift(B).
  - WB: R[rd] <= {C, sximm8, mdata, PC} according to kind. done = 1.
- Latency, accept edge to done-cycle edge: ALU 4, CMP 3, MOVR 3, MOVI/LDM/LDPC 1. A new command can be accepted in the cycle after done.
- Arithmetic:
  - Modulo 2^DW.
  - SUB = Ain + ~Bin + 1.
  - MVN = ~Bin (Ain ignored).
  - Shifts are by one bit: LSL1 drops the MSB, ASR1 replicates the MSB.
- Status:
  - Updated only in EXEC of ALU/CMP.
  - Z = (result==0). N = result[DW-1].
  - V = signed overflow for ADD/SUB; V = 0 for AND/MVN.
  - MOVR and the load kinds leave status unchanged.
- Regfile: write occurs at the WB edge only. rd == rn/rm is legal; the read happened in earlier states.
- Reserved cmd_kind: the command is accepted, done pulses the next cycle, and there is no state change.

Optional Feature:
- Macro DATAPATH_SEQ_DUALREAD_EN.
- When defined: regfile has two read ports; RDA and RDB merge into one state RDAB (A and B loaded together). ALU latency is 3 and CMP latency is 2.
- When undefined: single read port, latencies as above.

Decomposition:
- Package datapath_seq_pkg holds:
  - enums cmd_kind_t, aluop_t, shift_t, state_t;
  - status bit index constants.
- One sub-module, dp_regfile:
  - parametrised DW/NREG, 1 write port;
  - 1 or 2 read ports, plus a debug read port;
  - async reset.

Test Plan:
- MOVI R2,#13; MOVI R3,#42; ALU ADD R5,R3,R2 -> done after 4 cycles; datapath_out=55, dbg R5=55, status=000.
- MOVI R0,#7; MOVI R1,#2; ALU ADD R2,R1,R0 LSL1 -> R2=16.
- CMP R0,R0 (R0=5) -> Z=1, N=0, V=0, no register written. Then MOVI R1,#0x8000, MOVI R3,#1, CMP R1,R3 -> result 0x7FFF, V=1, N=0, Z=0.
- Offer a second command with cmd_valid=1 during the busy cycles of an ALU op -> cmd_ready=0, second command ignored; it is accepted only in the IDLE cycle after done.
- Assert reset_n=0 during EXEC of ADD R4,... -> R4 stays 0, all outputs 0, cmd_ready=1 after release.
- With DATAPATH_SEQ_DUALREAD_EN: the ADD from the first test completes in 3 cycles with the same results. With DW=32, NREG=16: MOVI R15,#-1; ALU MVN R14,R15 -> R14=0, Z=1.
